// File: rtl/sel_pipe_mux.sv
// rtl/sel_pipe_mux.sv - registered N:1 channel selector with fixed and round-robin arbitration
module sel_pipe_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  g;
    logic             grant;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    // The output register can take new data when empty or when it drains this cycle
    always_comb begin
        can_accept = !out_valid || out_ready;
        xfer       = grant && can_accept && !rst;
    end

    // Grant selection: fixed channel, or first valid channel at or after ptr, wrapping to 0
    always_comb begin
        grant = 1'b0;
        g     = '0;
        if (mode) begin
            for (int i = 0; i < N; i++) begin
                if (!grant && in_valid[i] && (SELW'(i) >= ptr)) begin
                    grant = 1'b1;
                    g     = SELW'(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!grant && in_valid[i]) begin
                    grant = 1'b1;
                    g     = SELW'(i);
                end
            end
        end else begin
            // sel values >= N match no channel, so they never grant
            for (int i = 0; i < N; i++) begin
                if ((sel == SELW'(i)) && in_valid[i]) begin
                    grant = 1'b1;
                    g     = SELW'(i);
                end
            end
        end
    end

    // One-hot ready to the granted channel and the matching data word
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SELW'(i)) begin
                in_ready[i] = xfer;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register, round-robin pointer update and drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= g;
                if (mode) begin
                    ptr <= (g == SELW'(N-1)) ? '0 : g + SELW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sel_pipe_mux.md
# sel_pipe_mux

Parametrised, registered N:1 channel selector with valid/ready handshakes on every input and on the output. It generalises the processor's combinational 8x1 32-bit multiplexer: width and channel count are parameters, it has a fixed-select or round-robin arbitration mode, and it has a one-entry output register. It sits between multiple producers (e.g. writeback sources, bus masters) and a single consumer in the femtoRV32 datapath, providing one-cycle latency at full throughput.

## Interface
- WIDTH, 32, data bits per channel
- N, 8, number of input channels (N ≥ 2)
- SELW, $clog2(N), derived; width of select and channel-index fields
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = fixed select (sel), 1 = round-robin
- sel  in  SELW  channel index used in fixed mode
- in_valid  in  N  per-channel data valid
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept (combinational); at most one bit high
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accepts output
- out_data  out  WIDTH  registered selected data
- out_ch  out  SELW  index of channel that supplied out_data

## Operation
- can_accept = !out_valid | out_ready.
- Grant, fixed mode: g = sel if sel < N and in_valid[sel]; otherwise no grant. Other channels never granted, even if valid.
- Grant, round-robin mode: g = first i with in_valid[i] = 1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1. No grant if in_valid = 0.
- in_ready[g] = can_accept when a grant exists; all other in_ready bits = 0. in_ready may depend combinationally on in_valid, sel, mode, out_ready.
- Transfer on input when in_valid[g] & in_ready[g]: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- No input transfer and out_ready & out_valid: out_valid <= 0; out_data/out_ch hold their last values.
- out_valid & !out_ready: out_data, out_ch, out_valid all held stable (AXI-style: no retraction).
- Round-robin pointer ptr (SELW bits): after a round-robin transfer from g, ptr <= (g == N-1) ? 0 : g+1. ptr is unchanged by fixed-mode transfers and by idle cycles.
- mode and sel are sampled every cycle; a change affects the next grant only; the registered output is never disturbed.
- Non-power-of-two N: ptr wraps at N-1, never takes values ≥ N; sel ≥ N gives no grant.

## Timing
- Reset (rst high at a clk edge): out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. in_ready is then all 0 only if no channel is valid, since can_accept = 1 after reset.
- rst overrides any transfer in the same cycle; data in flight is dropped, and the input handshake of that cycle is not counted as a transfer (in_ready forced 0 while rst = 1).
- Latency: input transfer at edge k, out_valid at edge k visible in cycle k+1.
- Throughput: one transfer per cycle with out_ready held high; simultaneous drain and fill in the same cycle replaces the register contents without a bubble.
- No combinational path from in_data to out_data.

## Test plan
- Reset: assert rst 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0 during reset; first grant after release in RR mode is channel 0.
- Fixed mode, N=8: sel=5, in_valid=8'hFF, in_data[5]=32'hDEADBEEF, out_ready=1 -> in_ready=8'h20; next cycle out_valid=1, out_data=32'hDEADBEEF, out_ch=5; ptr unchanged.
- Round-robin fairness: in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_ch sequence 0,1,…,7,0,1; in_valid=8'b1000_0100 -> alternates 2,7,2,7.
- Backpressure: out_valid=1 with out_data=32'h1234, out_ready=0 for 3 cycles while inputs change -> out_data, out_ch constant, in_ready=0; out_ready=1 -> new data registered the same cycle, no bubble.
- Non-power-of-two N=5: in_valid=5'b10001 in RR mode -> grants 0,4,0,4; ptr never exceeds 4; fixed mode with sel=6 -> in_ready=0, no transfer.
- Mid-operation reset: out_valid=1, out_ready=0, then rst=1 for 1 cycle -> out_valid=0, out_data=0, ptr=0 on the next cycle.
